// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates RV32 branch conditions, computes target/redirect,
// flags mispredicts and keeps saturating retire statistics. PIPE=1 splits the compare into halves.
module branch_resolve_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int PIPE   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic [2:0]        br_type,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic              pred_taken,
    output logic              out_valid,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              illegal,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mis_count
);
    localparam int HALF = XLEN / 2;

    logic              c_valid, c_eq, c_ltu, c_sgn1, c_sgn2, c_pred;
    logic [2:0]        c_type;
    logic [ADDR_W-1:0] c_target, c_pc4;
    logic              c_lt, c_taken, c_illegal, res_valid, retire;

    generate
        if (PIPE == 0) begin : g_single
            assign c_valid  = in_valid;
            assign c_eq     = (rdata1 == rdata2);
            assign c_ltu    = (rdata1 < rdata2);
            assign c_sgn1   = rdata1[XLEN-1];
            assign c_sgn2   = rdata2[XLEN-1];
            assign c_type   = br_type;
            assign c_target = pc + imm;
            assign c_pc4    = pc + ADDR_W'(4);
            assign c_pred   = pred_taken;
        end else begin : g_split
            logic              s1_valid, eq_hi, eq_lo, ltu_hi, ltu_lo, sgn1_q, sgn2_q, pred_q;
            logic [2:0]        type_q;
            logic [ADDR_W-1:0] target_q, pc4_q;

            // Half-width compares keep the carry chain short; stage 2 stitches them together.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    eq_hi    <= 1'b0;
                    eq_lo    <= 1'b0;
                    ltu_hi   <= 1'b0;
                    ltu_lo   <= 1'b0;
                    sgn1_q   <= 1'b0;
                    sgn2_q   <= 1'b0;
                    pred_q   <= 1'b0;
                    type_q   <= '0;
                    target_q <= '0;
                    pc4_q    <= '0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (!stall) begin
                    s1_valid <= in_valid;
                    eq_hi    <= (rdata1[XLEN-1:HALF] == rdata2[XLEN-1:HALF]);
                    eq_lo    <= (rdata1[HALF-1:0] == rdata2[HALF-1:0]);
                    ltu_hi   <= (rdata1[XLEN-1:HALF] < rdata2[XLEN-1:HALF]);
                    ltu_lo   <= (rdata1[HALF-1:0] < rdata2[HALF-1:0]);
                    sgn1_q   <= rdata1[XLEN-1];
                    sgn2_q   <= rdata2[XLEN-1];
                    pred_q   <= pred_taken;
                    type_q   <= br_type;
                    target_q <= pc + imm;
                    pc4_q    <= pc + ADDR_W'(4);
                end
            end

            assign c_valid  = s1_valid;
            assign c_eq     = eq_hi & eq_lo;
            assign c_ltu    = ltu_hi | (eq_hi & ltu_lo);
            assign c_sgn1   = sgn1_q;
            assign c_sgn2   = sgn2_q;
            assign c_type   = type_q;
            assign c_target = target_q;
            assign c_pc4    = pc4_q;
            assign c_pred   = pred_q;
        end
    endgenerate

    assign c_lt      = (c_sgn1 != c_sgn2) ? c_sgn1 : c_ltu;
    assign c_illegal = (c_type[2:1] == 2'b11);
    assign res_valid = c_valid & !flush;
    assign retire    = out_valid & !stall & !flush;

    always_comb begin
        c_taken = 1'b0;
        case (c_type)
            3'b000:  c_taken = c_eq;
            3'b001:  c_taken = !c_eq;
            3'b010:  c_taken = c_lt;
            3'b011:  c_taken = !c_lt;
            3'b100:  c_taken = c_ltu;
            3'b101:  c_taken = !c_ltu;
            default: c_taken = 1'b0;
        endcase
    end

    // Outputs are zeroed whenever no result is presented so downstream never sees stale redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            br_taken    <= 1'b0;
            br_target   <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            illegal     <= 1'b0;
        end else if (flush || !stall) begin
            out_valid   <= res_valid;
            br_taken    <= res_valid & c_taken;
            br_target   <= res_valid ? c_target : '0;
            mispredict  <= res_valid & (c_taken != c_pred);
            redirect_pc <= res_valid ? (c_taken ? c_target : c_pc4) : '0;
            illegal     <= res_valid & c_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (clr_stats) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (retire) begin
            if (br_count != {CNT_W{1'b1}})
                br_count <= br_count + CNT_W'(1);
            if (mispredict && (mis_count != {CNT_W{1'b1}}))
                mis_count <= mis_count + CNT_W'(1);
        end
    end
endmodule
